// File: rtl/cntn_ud.sv
// cntn_ud: N-bit up/down event/timer counter with a runtime terminal limit,
// parallel load, wrap-or-saturate bound handling, combinational terminal
// count, a registered wrap pulse and a sticky overflow flag.
module cntn_ud #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         enable,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dir,
    input  logic [N-1:0] limit,
    input  logic         sat,
    output logic [N-1:0] cnt_out,
    output logic         tc,
    output logic         wrap_o,
    output logic         ovf
);

    logic [N-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    logic         ovf_q, ovf_d;

    // Bound conditions for the current direction. The up bound uses >= so a
    // count loaded above the limit is treated as already at the bound.
    logic at_top;
    logic at_bottom;

    assign at_top    = (cnt_q >= limit);
    assign at_bottom = (cnt_q == '0);

    // Next-state selection with priority clear > load > enable.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (clear) begin
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else if (load) begin
            // Loaded value is taken as-is, even when above the limit.
            cnt_d  = load_val;
        end else if (enable) begin
            if (dir) begin
                if (!at_top) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (sat) begin
                    // Hold at the limit, or clamp down if loaded above it.
                    cnt_d = limit;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end
            end else begin
                if (!at_bottom) begin
                    // Decrement also applies when the count sits above the limit.
                    cnt_d = cnt_q - 1'b1;
                end else if (sat) begin
                    cnt_d = '0;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d  = limit;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // Terminal count: bound reached in the active direction, only while
    // enabled; deliberately not gated by clear or load.
    assign tc      = enable & ((dir & at_top) | (~dir & at_bottom));

    assign cnt_out = cnt_q;
    assign wrap_o  = wrap_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_cntn_ud.sv
// Self-checking bench for cntn_ud: directed scenarios plus a randomized run
// against a behavioural model of the counter rules.
module tb_cntn_ud;

    localparam int N   = 10;
    localparam int MAX = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         res_n;
    logic         enable;
    logic         clear;
    logic         load;
    logic [N-1:0] load_val;
    logic         dir;
    logic [N-1:0] limit;
    logic         sat;
    logic [N-1:0] cnt_out;
    logic         tc;
    logic         wrap_o;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    // Behavioural model state (plain integers).
    int m_cnt  = 0;
    int m_wrap = 0;
    int m_ovf  = 0;

    cntn_ud #(.N(N)) dut (
        .clk      (clk),
        .res_n    (res_n),
        .enable   (enable),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .limit    (limit),
        .sat      (sat),
        .cnt_out  (cnt_out),
        .tc       (tc),
        .wrap_o   (wrap_o),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Apply the counter rules to the model for one rising edge.
    task automatic model_step();
        int lim;
        lim = int'(limit);
        if (!res_n || clear) begin
            m_cnt = 0; m_wrap = 0; m_ovf = 0;
        end else if (load) begin
            m_cnt = int'(load_val); m_wrap = 0;
        end else if (!enable) begin
            m_wrap = 0;
        end else if (dir) begin
            m_wrap = 0;
            if (m_cnt < lim) m_cnt = m_cnt + 1;
            else begin
                m_ovf = 1;
                if (sat) m_cnt = lim;
                else begin m_cnt = 0; m_wrap = 1; end
            end
        end else begin
            m_wrap = 0;
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            else begin
                m_ovf = 1;
                if (!sat) begin m_cnt = lim; m_wrap = 1; end
            end
        end
    endtask

    function automatic int model_tc();
        if (!enable) return 0;
        if (dir) return (m_cnt >= int'(limit)) ? 1 : 0;
        return (m_cnt == 0) ? 1 : 0;
    endfunction

    // One clock edge; model follows the same edge; outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_idle();
        res_n = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
        load_val = '0; dir = 1'b1; limit = N'(MAX); sat = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_reset();
        res_n = 1'b0; enable = 1'b1; load = 1'b1; load_val = 10'h155;
        clear = 1'b0; dir = 1'b1; sat = 1'b0; limit = N'(MAX);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (cnt_out !== 10'd0 || wrap_o !== 1'b0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got cnt=%0d wrap=%b ovf=%b want 0/0/0", i, cnt_out, wrap_o, ovf);
            end
        end
        res_n = 1'b1; load = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (cnt_out !== N'(i)) begin
                bad++;
                $display("FAIL reset_release got=%0d want=%0d", cnt_out, i);
            end
        end
    endtask

    task automatic test_up_wrap();
        int seq [7] = '{1, 2, 3, 4, 5, 0, 1};
        int prev;
        enable = 1'b0; do_clear();
        limit = 10'd5; dir = 1'b1; sat = 1'b0; enable = 1'b1;
        prev = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            total++;
            if (tc !== (prev == 5)) begin
                bad++;
                $display("FAIL up_wrap_tc cnt=%0d got=%b want=%b", prev, tc, prev == 5);
            end
            tick();
            total++;
            if (cnt_out !== N'(seq[i]) || wrap_o !== (seq[i] == 0) || ovf !== (i >= 5)) begin
                bad++;
                $display("FAIL up_wrap step=%0d got cnt=%0d wrap=%b ovf=%b want %0d/%b/%b",
                         i, cnt_out, wrap_o, ovf, seq[i], seq[i] == 0, i >= 5);
            end
            prev = seq[i];
        end
        enable = 1'b0; do_clear();
        total++;
        if (cnt_out !== 10'd0 || ovf !== 1'b0 || wrap_o !== 1'b0) begin
            bad++;
            $display("FAIL up_wrap_clear got cnt=%0d ovf=%b wrap=%b want 0/0/0", cnt_out, ovf, wrap_o);
        end
    endtask

    task automatic test_saturate();
        int up [7]  = '{1, 2, 3, 4, 5, 5, 5};
        int dn [7]  = '{4, 3, 2, 1, 0, 0, 0};
        int pre [7] = '{5, 4, 3, 2, 1, 0, 0};
        enable = 1'b0; do_clear();
        limit = 10'd5; dir = 1'b1; sat = 1'b1; enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (cnt_out !== N'(up[i]) || wrap_o !== 1'b0 || ovf !== (i >= 5)) begin
                bad++;
                $display("FAIL sat_up step=%0d got cnt=%0d wrap=%b ovf=%b want %0d/0/%b",
                         i, cnt_out, wrap_o, ovf, up[i], i >= 5);
            end
        end
        dir = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            total++;
            if (tc !== (pre[i] == 0)) begin
                bad++;
                $display("FAIL sat_dn_tc cnt=%0d got=%b want=%b", pre[i], tc, pre[i] == 0);
            end
            tick();
            total++;
            if (cnt_out !== N'(dn[i]) || wrap_o !== 1'b0 || ovf !== 1'b1) begin
                bad++;
                $display("FAIL sat_dn step=%0d got cnt=%0d wrap=%b ovf=%b want %0d/0/1",
                         i, cnt_out, wrap_o, ovf, dn[i]);
            end
        end
    endtask

    task automatic test_down_wrap();
        int seq [3] = '{1023, 1022, 1021};
        enable = 1'b0; do_clear();
        dir = 1'b0; sat = 1'b0; limit = 10'd1023; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (cnt_out !== N'(seq[i]) || wrap_o !== (i == 0) || ovf !== 1'b1) begin
                bad++;
                $display("FAIL down_wrap step=%0d got cnt=%0d wrap=%b ovf=%b want %0d/%b/1",
                         i, cnt_out, wrap_o, ovf, seq[i], i == 0);
            end
        end
    endtask

    task automatic test_load_above_limit();
        enable = 1'b1; limit = 10'd100; dir = 1'b1; sat = 1'b0;
        load = 1'b1; load_val = 10'd900; tick(); load = 1'b0;
        total++;
        if (cnt_out !== 10'd900 || wrap_o !== 1'b0) begin
            bad++;
            $display("FAIL load_900 got cnt=%0d wrap=%b want 900/0", cnt_out, wrap_o);
        end
        tick();
        total++;
        if (cnt_out !== 10'd0 || wrap_o !== 1'b1) begin
            bad++;
            $display("FAIL load_wrap got cnt=%0d wrap=%b want 0/1", cnt_out, wrap_o);
        end
        load = 1'b1; tick(); load = 1'b0; dir = 1'b0;
        tick();
        total++;
        if (cnt_out !== 10'd899) begin
            bad++;
            $display("FAIL load_down1 got=%0d want=899", cnt_out);
        end
        tick();
        total++;
        if (cnt_out !== 10'd898) begin
            bad++;
            $display("FAIL load_down2 got=%0d want=898", cnt_out);
        end
        dir = 1'b1; sat = 1'b1; load = 1'b1; tick(); load = 1'b0;
        tick();
        total++;
        if (cnt_out !== 10'd100 || wrap_o !== 1'b0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL load_clamp got cnt=%0d wrap=%b ovf=%b want 100/0/1", cnt_out, wrap_o, ovf);
        end
    endtask

    task automatic test_priority();
        enable = 1'b1; dir = 1'b1; sat = 1'b0; limit = 10'd5;
        clear = 1'b1; load = 1'b1; load_val = 10'd9; tick();
        clear = 1'b0;
        total++;
        if (cnt_out !== 10'd0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL clear_over_load got cnt=%0d ovf=%b want 0/0", cnt_out, ovf);
        end
        load_val = 10'd7; tick(); load = 1'b0;
        total++;
        if (cnt_out !== 10'd7) begin
            bad++;
            $display("FAIL load_over_enable got=%0d want=7", cnt_out);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (tc !== 1'b0) begin
                bad++;
                $display("FAIL hold_tc got=%b want=0", tc);
            end
            tick();
            total++;
            if (cnt_out !== 10'd7 || wrap_o !== 1'b0) begin
                bad++;
                $display("FAIL hold got cnt=%0d wrap=%b want 7/0", cnt_out, wrap_o);
            end
        end
    endtask

    task automatic test_limit_zero();
        enable = 1'b0; do_clear();
        limit = 10'd0; sat = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dir = i[0];
            tick();
            total++;
            if (cnt_out !== 10'd0 || wrap_o !== 1'b1 || ovf !== 1'b1) begin
                bad++;
                $display("FAIL lim0_wrap got cnt=%0d wrap=%b ovf=%b want 0/1/1", cnt_out, wrap_o, ovf);
            end
        end
        sat = 1'b1;
        tick();
        total++;
        if (cnt_out !== 10'd0 || wrap_o !== 1'b0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL lim0_sat got cnt=%0d wrap=%b ovf=%b want 0/0/1", cnt_out, wrap_o, ovf);
        end
    endtask

    task automatic test_reset_midcount();
        enable = 1'b0; do_clear();
        limit = 10'd3; dir = 1'b1; sat = 1'b0; enable = 1'b1;
        repeat (4) tick();
        res_n = 1'b0; clear = 1'b1; load = 1'b1; load_val = 10'd55; tick();
        res_n = 1'b1; clear = 1'b0; load = 1'b0; enable = 1'b0;
        total++;
        if (cnt_out !== 10'd0 || wrap_o !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got cnt=%0d wrap=%b ovf=%b want 0/0/0", cnt_out, wrap_o, ovf);
        end
    endtask

    task automatic test_random();
        set_idle(); do_clear();
        for (int i = 0; i < 2000; i++) begin
            res_n    = ($urandom_range(0, 63) != 0);
            clear    = ($urandom_range(0, 31) == 0);
            load     = ($urandom_range(0, 11) == 0);
            enable   = ($urandom_range(0, 3) != 0);
            dir      = $urandom_range(0, 1);
            sat      = ($urandom_range(0, 2) == 0);
            load_val = N'($urandom);
            limit    = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 12));
            #1;
            total++;
            if (tc !== model_tc()) begin
                bad++;
                $display("FAIL rand_tc i=%0d got=%b want=%0d", i, tc, model_tc());
            end
            tick();
            total++;
            if (cnt_out !== N'(m_cnt) || wrap_o !== m_wrap[0] || ovf !== m_ovf[0]) begin
                bad++;
                $display("FAIL rand i=%0d got cnt=%0d wrap=%b ovf=%b want %0d/%0d/%0d",
                         i, cnt_out, wrap_o, ovf, m_cnt, m_wrap, m_ovf);
            end
        end
    endtask

    initial begin
        set_idle();
        res_n = 1'b0;
        test_reset();
        test_up_wrap();
        test_saturate();
        test_down_wrap();
        test_load_above_limit();
        test_priority();
        test_limit_zero();
        test_reset_midcount();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
